usr5_tx_ctrl: RTL and testbench

Sequencing controller for the 5-bit universal shift register (universal_sr_5bit).
- Accepts a parallel word over a valid/ready handshake.
- Drives the register's sel/pi/si to parallel-load the word, then shift it out serially, LSB- or MSB-first.
- Frames the serial stream with valid/start/end strobes and inserts a configurable idle gap between words.
- Sits between a word producer and the shift-register datapath; the register's so is fed back for the framed output.

---
 rtl/usr_pkg.sv | 17 +
 rtl/universal_sr_5bit.sv | 33 +++
 rtl/usr5_tx_ctrl.sv | 114 +++++++++++
 tb/tb_usr5_tx_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the 5-bit universal shift register and its TX sequencer.
package usr_pkg;

  // Register mode select encoding
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/universal_sr_5bit.sv
// Universal shift register: hold / shift right / shift left / parallel load.
// so presents the bit leaving the register in the selected shift direction.
module universal_sr_5bit
  import usr_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] pi,
  input  logic             si,
  output logic             so,
  output logic [WIDTH-1:0] q
);

  // Storage update by mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else begin
      case (sel)
        SEL_SHR:  q <= {si, q[WIDTH-1:1]};
        SEL_SHL:  q <= {q[WIDTH-2:0], si};
        SEL_LOAD: q <= pi;
        default:  q <= q;
      endcase
    end
  end

  // Outgoing bit: MSB when shifting left, LSB otherwise
  always_comb so = (sel == SEL_SHL) ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/usr5_tx_ctrl.sv
// TX sequencer: accepts a word, parallel-loads the shift register, shifts it
// out framed with start/end strobes, then holds for an idle gap.
module usr5_tx_ctrl
  import usr_pkg::*;
#(
  parameter int   WIDTH      = 5,
  parameter int   GAP_CYCLES = 2,
  parameter logic FILL       = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             lsb_first,
  input  logic             abort,
  output logic [1:0]       sr_sel,
  output logic [WIDTH-1:0] sr_pi,
  output logic             sr_si,
  input  logic             sr_so,
  output logic             ser_data,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state, nxt;
  logic [WIDTH-1:0] word;
  logic             dir;
  logic [CW-1:0]    cnt;
  logic [GW-1:0]    gcnt;
  logic             done_q;
  logic             accept;
  logic             last_bit;

  assign accept   = (state == IDLE) && in_valid && !abort;
  assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state and register-control decode from the current state
  always_comb begin
    nxt         = state;
    in_ready    = 1'b0;
    sr_sel      = SEL_HOLD;
    sr_pi       = '0;
    sr_si       = FILL;
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) nxt = LOAD;
      end
      LOAD: begin
        sr_sel = SEL_LOAD;
        sr_pi  = word;
        nxt    = SHIFT;
      end
      SHIFT: begin
        sr_sel      = dir ? SEL_SHR : SEL_SHL;
        ser_valid   = 1'b1;
        frame_start = (cnt == '0);
        frame_end   = (cnt == CNT_LAST);
        if (cnt == CNT_LAST) nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gcnt == GAP_LAST) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    // Abort discards the in-flight word from any active state
    if (abort && state != IDLE) nxt = IDLE;
  end

  // Word capture, bit/gap counters and the done strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word   <= '0;
      dir    <= 1'b0;
      cnt    <= '0;
      gcnt   <= '0;
      done_q <= 1'b0;
    end else begin
      if (accept) begin
        word <= in_data;
        dir  <= lsb_first;
      end
      if (state == SHIFT) cnt <= cnt + 1'b1;
      else                cnt <= '0;
      // Saturate rather than wrap if GAP is held longer than expected
      if (state != GAP)          gcnt <= '0;
      else if (gcnt != GAP_LAST) gcnt <= gcnt + 1'b1;
      done_q <= last_bit && !abort;
    end
  end

  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign ser_data = sr_so & ser_valid;

endmodule

// File: tb/tb_usr5_tx_ctrl.sv
// Directed bench: controller + shift register, default gap and zero-gap builds.
module tb_usr5_tx_ctrl;
  import usr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Instance A: GAP_CYCLES=2
  logic       a_in_valid, a_in_ready, a_lsb, a_abort;
  logic [4:0] a_in_data, a_pi, a_q;
  logic [1:0] a_sel;
  logic       a_si, a_so, a_sd, a_sv, a_fs, a_fe, a_busy, a_done;

  usr5_tx_ctrl #(.WIDTH(5), .GAP_CYCLES(2), .FILL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .lsb_first(a_lsb), .abort(a_abort),
    .sr_sel(a_sel), .sr_pi(a_pi), .sr_si(a_si), .sr_so(a_so),
    .ser_data(a_sd), .ser_valid(a_sv), .frame_start(a_fs), .frame_end(a_fe),
    .busy(a_busy), .done(a_done));
  universal_sr_5bit #(.WIDTH(5)) sr_a (
    .clk(clk), .rst(rst), .sel(a_sel), .pi(a_pi), .si(a_si), .so(a_so), .q(a_q));

  // Instance B: GAP_CYCLES=0
  logic       b_in_valid, b_in_ready, b_lsb, b_abort;
  logic [4:0] b_in_data, b_pi, b_q;
  logic [1:0] b_sel;
  logic       b_si, b_so, b_sd, b_sv, b_fs, b_fe, b_busy, b_done;

  usr5_tx_ctrl #(.WIDTH(5), .GAP_CYCLES(0), .FILL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .lsb_first(b_lsb), .abort(b_abort),
    .sr_sel(b_sel), .sr_pi(b_pi), .sr_si(b_si), .sr_so(b_so),
    .ser_data(b_sd), .ser_valid(b_sv), .frame_start(b_fs), .frame_end(b_fe),
    .busy(b_busy), .done(b_done));
  universal_sr_5bit #(.WIDTH(5)) sr_b (
    .clk(clk), .rst(rst), .sel(b_sel), .pi(b_pi), .si(b_si), .so(b_so), .q(b_q));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Five SHIFT cycles; seq holds the expected bits first-to-last from MSB down
  task automatic stream(input bit b, input logic [4:0] seq, input logic [1:0] sel, input string tag);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk({tag, " sv"},   b ? b_sv  : a_sv,  1'b1);
      chk({tag, " sd"},   b ? b_sd  : a_sd,  seq[4-i]);
      chk({tag, " sel"},  b ? b_sel : a_sel, sel);
      chk({tag, " fs"},   b ? b_fs  : a_fs,  (i == 0));
      chk({tag, " fe"},   b ? b_fe  : a_fe,  (i == 4));
      chk({tag, " done"}, b ? b_done : a_done, 1'b0);
    end
  endtask

  // Full word on A starting from an IDLE negedge, ending on the next IDLE negedge
  task automatic send_a(input logic [4:0] w, input logic lsb, input logic [4:0] seq,
                        input logic [1:0] sel, input string tag);
    chk({tag, " rdy0"}, a_in_ready, 1'b1);
    a_in_valid = 1'b1; a_in_data = w; a_lsb = lsb;
    @(negedge clk);
    chk({tag, " ld sel"}, a_sel, 2'b11);
    chk({tag, " ld pi"},  a_pi, w);
    chk({tag, " ld rdy"}, a_in_ready, 1'b0);
    a_in_valid = 1'b0;
    stream(1'b0, seq, sel, tag);
    @(negedge clk);
    chk({tag, " g1 done"}, a_done, 1'b1);
    chk({tag, " g1 sel"},  a_sel, 2'b00);
    chk({tag, " g1 sv"},   a_sv, 1'b0);
    chk({tag, " g1 rdy"},  a_in_ready, 1'b0);
    @(negedge clk);
    chk({tag, " g2 done"}, a_done, 1'b0);
    chk({tag, " g2 rdy"},  a_in_ready, 1'b0);
    @(negedge clk);
    chk({tag, " idle rdy"},  a_in_ready, 1'b1);
    chk({tag, " idle busy"}, a_busy, 1'b0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_lsb = 0; a_abort = 0;
    b_in_valid = 0; b_in_data = '0; b_lsb = 0; b_abort = 0;
    repeat (2) @(negedge clk);
    chk("rst rdy",  a_in_ready, 1'b1);
    chk("rst sel",  a_sel, 2'b00);
    chk("rst pi",   a_pi, 5'd0);
    chk("rst si",   a_si, 1'b0);
    chk("rst sv",   a_sv, 1'b0);
    chk("rst busy", a_busy, 1'b0);
    chk("rst done", a_done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // LSB-first and MSB-first of the same word
    send_a(5'b11010, 1'b1, 5'b01011, 2'b01, "lsb");
    send_a(5'b11010, 1'b0, 5'b11010, 2'b10, "msb");

    // abort together with in_valid in IDLE: no accept
    a_in_valid = 1'b1; a_abort = 1'b1; a_in_data = 5'b00111; a_lsb = 1'b1;
    @(negedge clk);
    chk("abidle rdy",  a_in_ready, 1'b1);
    chk("abidle busy", a_busy, 1'b0);
    a_in_valid = 1'b0; a_abort = 1'b0;

    // Back-to-back with in_valid held
    a_in_valid = 1'b1; a_in_data = 5'b10001; a_lsb = 1'b1;
    cyc = 0;
    @(negedge clk); cyc++;
    chk("b2b ld1 pi", a_pi, 5'b10001);
    a_in_data = 5'b01110;
    stream(1'b0, 5'b10001, 2'b01, "b2b w1");
    cyc += 5;
    for (int i = 0; i < 10 && !a_in_ready; i++) begin
      @(negedge clk); cyc++;
    end
    chk("b2b spacing", cyc, 9);
    @(negedge clk);
    chk("b2b ld2 sel", a_sel, 2'b11);
    chk("b2b ld2 pi",  a_pi, 5'b01110);
    a_in_valid = 1'b0;
    stream(1'b0, 5'b01110, 2'b01, "b2b w2");
    repeat (3) @(negedge clk);
    chk("b2b idle", a_in_ready, 1'b1);

    // Abort in the 3rd SHIFT cycle
    a_in_valid = 1'b1; a_in_data = 5'b11111; a_lsb = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort s3 sv", a_sv, 1'b1);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    chk("abort sv",   a_sv, 1'b0);
    chk("abort sel",  a_sel, 2'b00);
    chk("abort rdy",  a_in_ready, 1'b1);
    chk("abort done", a_done, 1'b0);
    @(negedge clk);
    chk("abort done2", a_done, 1'b0);

    // Zero-gap instance
    b_in_valid = 1'b1; b_in_data = 5'b11010; b_lsb = 1'b1;
    @(negedge clk);
    chk("g0 ld sel", b_sel, 2'b11);
    b_in_valid = 1'b0;
    stream(1'b1, 5'b01011, 2'b01, "g0 w1");
    @(negedge clk);
    chk("g0 idle rdy", b_in_ready, 1'b1);
    chk("g0 idle done", b_done, 1'b1);
    chk("g0 idle sv", b_sv, 1'b0);
    b_in_valid = 1'b1; b_in_data = 5'b10001; b_lsb = 1'b1;
    @(negedge clk);
    chk("g0 ld2 sel", b_sel, 2'b11);
    chk("g0 ld2 pi",  b_pi, 5'b10001);
    chk("g0 ld2 done", b_done, 1'b0);
    b_in_valid = 1'b0;
    stream(1'b1, 5'b10001, 2'b01, "g0 w2");
    @(negedge clk);
    chk("g0 done2", b_done, 1'b1);

    // Reset mid-SHIFT, between edges
    a_in_valid = 1'b1; a_in_data = 5'b11010; a_lsb = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid sv pre", a_sv, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid rst sel",  a_sel, 2'b00);
    chk("mid rst pi",   a_pi, 5'd0);
    chk("mid rst rdy",  a_in_ready, 1'b1);
    chk("mid rst sv",   a_sv, 1'b0);
    chk("mid rst sd",   a_sd, 1'b0);
    chk("mid rst fs",   a_fs, 1'b0);
    chk("mid rst busy", a_busy, 1'b0);
    chk("mid rst done", a_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    send_a(5'b00101, 1'b1, 5'b10100, 2'b01, "post");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
